fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin burst arbiter sharing one synfifo write port among NUM_REQ producers.
//   Each producer uses a valid/ready handshake. The winner owns the port for up to BURST_LEN beats.
//   Flow control uses the FIFO's registered occupancy (fifo_num) plus the in-flight registered write.
//   The full/almost_full flags are combinational on wr, so they are not used, and no loop is formed.
// PARAMETERS
//   NUM_REQ    4  number of producers (2..8)
//   ID_W       2  width of grant_id; must be >= clog2(NUM_REQ)
//   DATA_W     5  data width; equals FIFO data_width
//   DEPTH      8  FIFO depth; equals FIFO data_depth
//   DEPTH_W    3  FIFO depth_width; fifo_num is DEPTH_W+1 bits
//   BURST_LEN  4  max beats per grant (1..2^DEPTH_W)
// PORTS
//   clk           in   1               clock
//   rst           in   1               asynchronous reset, active-high
//   req_vld       in   NUM_REQ         producer i has a beat
//   req_last      in   NUM_REQ         beat is the last of the producer's packet
//   req_data      in   NUM_REQ*DATA_W  producer i data at [i*DATA_W +: DATA_W]
//   req_rdy       out  NUM_REQ         beat i accepted when req_vld[i] & req_rdy[i]
//   fifo_wr       out  1               registered write strobe to FIFO wr
//   fifo_wr_data  out  DATA_W          registered data to FIFO wr_data
//   fifo_num      in   DEPTH_W+1       FIFO occupancy (registered pointer difference)
//   grant_vld     out  1               a producer currently owns the port (state BURST)
//   grant_id      out  ID_W            current or most recent owner index
// BEHAVIOUR
//   Reset (async, rst=1):
//     - state=IDLE; fifo_wr=0; fifo_wr_data=0; req_rdy=0; grant_vld=0; grant_id=0.
//     - beat_cnt=0; rr_last=NUM_REQ-1, so producer 0 is considered first.
//   Reset mid-burst drops the burst; any beat not yet registered is lost.
//   space_ok = (DEPTH - fifo_num - fifo_wr) >= 1. Compute in DEPTH_W+2 bits; no underflow.
//   State IDLE:
//     - req_rdy=0.
//     - If any req_vld: winner = first i with req_vld[i], searching rr_last+1 upward and wrapping mod NUM_REQ.
//     - Next cycle: state=BURST, grant_id=winner, grant_vld=1, beat_cnt=0, rr_last=winner.
//     - Arbitration costs exactly one idle cycle between grants.
//   State BURST (owner = grant_id):
//     - req_rdy[owner] = space_ok; all other req_rdy bits are 0.
//     - req_rdy is combinational from state, owner, fifo_num and fifo_wr only. It never depends on req_vld.
//     - Accepted beat: next cycle fifo_wr=1 and fifo_wr_data=req_data[owner]; beat_cnt++.
//     - Otherwise next cycle fifo_wr=0, and fifo_wr_data holds its value.
//     - Exit to IDLE (grant_vld=0 next cycle) on either:
//       (a) an accepted beat with req_last[owner]=1 or beat_cnt==BURST_LEN-1;
//       (b) req_vld[owner]=0, which releases the grant immediately with no beat.
//     - Stall: if space_ok=0, hold grant and beat_cnt. The producer must hold req_vld and req_data stable.
//   Latency: accepted beat -> fifo_wr pulse on the next cycle. Throughput is 1 beat/cycle inside a burst.
//   FIFO never overflows: at most DEPTH writes are outstanding relative to fifo_num.
//   Simultaneous FIFO read is ignored conservatively; the freed slot is used one cycle later.
//   Simultaneous requests: the round-robin order from rr_last decides. No producer waits more than NUM_REQ-1 grants.
// CONFIGURATION
//   `FIFO_WR_ARB_PRIO_EN defined:
//     - In IDLE, producer 0 wins whenever req_vld[0]=1, regardless of rr_last.
//     - rr_last is not updated by a producer-0 grant; the others stay round-robin among themselves.
//   Not defined: pure round-robin across all producers as above.
// TESTING
//   1. Reset: rst=1 mid-burst with fifo_wr=1 -> all outputs 0 at once; after release, req_vld=4'b1111 grants id 0.
//   2. RR fairness: req_vld=4'b1111 held, req_last=0 -> grants 0,1,2,3,0, each 4 beats; fifo_wr pattern 4 on, 1 off.
//   3. req_last: producer 2 sends 2 beats with req_last on beat 2 -> grant drops after 2 beats; fifo_wr exactly 2 pulses.
//   4. Full backpressure: fifo_num=7, fifo_wr=1, no reads -> req_rdy=0; fifo_num->8 holds stall; one read -> accept resumes.
//   5. Release: owner drops req_vld after 1 beat -> IDLE next cycle; next requester is granted; beat_cnt restarts at 0.
//   6. `FIFO_WR_ARB_PRIO_EN: req_vld=4'b1010, then req_vld[0] rises during burst 1 -> next grant 0, then 3.
//      Same stimulus without the macro -> grant 3, then 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake and FIFO write-port bundle for fifo_wr_arbiter.
// master: arbiter side; slave: producers plus FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 5,
  parameter int DEPTH_W = 3
);
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_rdy;
  logic                      fifo_wr;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic [DEPTH_W:0]          fifo_num;
  logic                      grant_vld;
  logic [ID_W-1:0]           grant_id;

  modport master (
    input  req_vld, req_last, req_data, fifo_num,
    output req_rdy, fifo_wr, fifo_wr_data,
    output grant_vld, grant_id
  );

  modport slave (
    output req_vld, req_last, req_data, fifo_num,
    input  req_rdy, fifo_wr, fifo_wr_data,
    input  grant_vld, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// Define FIFO_WR_ARB_PRIO_EN to give producer 0 strict priority in IDLE.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int DATA_W    = 5,
  parameter int DEPTH     = 8,
  parameter int DEPTH_W   = 3,
  parameter int BURST_LEN = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int CNT_W = DEPTH_W + 1;
  localparam int SUM_W = DEPTH_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [SUM_W-1:0] DEPTH_V  = SUM_W'(DEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [ID_W-1:0]  rr_last;
  logic [ID_W-1:0]  win;
  logic [SUM_W-1:0] used;
  logic             space_ok;
  logic             any_vld;
  logic             own_vld;
  logic             own_last;
  logic [DATA_W-1:0] own_data;

  // Slots committed: registered occupancy plus the write in flight.
  assign used = {1'b0, bus.fifo_num}
              + {{(SUM_W-1){1'b0}}, bus.fifo_wr};
  assign space_ok = used < DEPTH_V;
  assign any_vld  = |bus.req_vld;
  assign own_vld  = bus.req_vld[bus.grant_id];
  assign own_last = bus.req_last[bus.grant_id];
  assign own_data =
    bus.req_data[int'(bus.grant_id)*DATA_W +: DATA_W];

  // Pick the next requester after rr_last, wrapping around.
  always_comb begin
    logic          found;
    logic [ID_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_last) + k) % NUM_REQ);
      if (!found && bus.req_vld[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`ifdef FIFO_WR_ARB_PRIO_EN
    if (bus.req_vld[0]) win = '0;
`endif
  end

  // Only the owner may be ready, and only while a slot is free.
  always_comb begin
    bus.req_rdy = '0;
    if (state == BURST) bus.req_rdy[bus.grant_id] = space_ok;
  end

  // Grant FSM with registered write port and grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      rr_last          <= ID_W'(NUM_REQ - 1);
      bus.fifo_wr      <= 1'b0;
      bus.fifo_wr_data <= '0;
      bus.grant_vld    <= 1'b0;
      bus.grant_id     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.fifo_wr <= 1'b0;
          if (any_vld) begin
            state         <= BURST;
            bus.grant_vld <= 1'b1;
            bus.grant_id  <= win;
            beat_cnt      <= '0;
`ifdef FIFO_WR_ARB_PRIO_EN
            if (win != '0) rr_last <= win;
`else
            rr_last <= win;
`endif
          end
        end
        BURST: begin
          if (!own_vld) begin
            state         <= IDLE;
            bus.grant_vld <= 1'b0;
            bus.fifo_wr   <= 1'b0;
          end else if (space_ok) begin
            bus.fifo_wr      <= 1'b1;
            bus.fifo_wr_data <= own_data;
            beat_cnt         <= beat_cnt + CNT_W'(1);
            if (own_last || beat_cnt == CNT_LAST) begin
              state         <= IDLE;
              bus.grant_vld <= 1'b0;
            end
          end else begin
            bus.fifo_wr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter.
// Vectors are driven at negedge and outputs sampled 1ns later.
module tb_fifo_wr_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] last;
    logic [3:0] num;
    logic [3:0] rdy;
    logic       wr;
    logic [4:0] data;
    logic       gv;
    logic [1:0] gid;
    logic       chkd;
  } vec_t;

`ifdef FIFO_WR_ARB_PRIO_EN
  localparam int P1 = 0;
  localparam int P2 = 3;
`else
  localparam int P1 = 3;
  localparam int P2 = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t q[$];
  int   napp = 0;
  int   nbad = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if bus ();

  fifo_wr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [4:0] dat(int i);
    return 5'(i * 7 + 3);
  endfunction

  assign bus.req_data = {dat(3), dat(2), dat(1), dat(0)};

  task automatic v(int r, int vl, int la, int nm,
                   int rd, int w, int d, int g, int id);
    vec_t e;
    e.rst  = 1'(r);
    e.vld  = 4'(vl);
    e.last = 4'(la);
    e.num  = 4'(nm);
    e.rdy  = 4'(rd);
    e.wr   = 1'(w);
    e.data = 5'(d);
    e.gv   = 1'(g);
    e.gid  = 2'(id);
    e.chkd = 1'(w) | 1'(r);
    q.push_back(e);
  endtask

  task automatic check(string nm, int idx, vec_t e);
    logic ok;
    ok = (bus.req_rdy === e.rdy) && (bus.fifo_wr === e.wr)
      && (bus.grant_vld === e.gv) && (bus.grant_id === e.gid)
      && (!e.chkd || bus.fifo_wr_data === e.data);
    napp++;
    if (!ok) begin
      nbad++;
      $display("FAIL %s #%0d: rdy=%b wr=%b data=%0d gv=%b gid=%0d, want rdy=%b wr=%b data=%0d gv=%b gid=%0d",
               nm, idx, bus.req_rdy, bus.fifo_wr, bus.fifo_wr_data,
               bus.grant_vld, bus.grant_id, e.rdy, e.wr, e.data,
               e.gv, e.gid);
    end
  endtask

  initial begin
    vec_t e;
    bus.req_vld  = '0;
    bus.req_last = '0;
    bus.fifo_num = '0;

    // reset, burst of 1, reset mid-burst while fifo_wr=1
    v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
    v(0, 4'b0010, 0, 0, 4'b0010, 0, 0, 1, 1);
    v(0, 4'b0010, 0, 0, 4'b0010, 1, dat(1), 1, 1);
    v(1, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
    v(0, 4'b1111, 0, 0, 0, 0, 0, 0, 0);
    // round robin 0,1,2,3,0 with 4-beat bursts
    for (int g = 0; g < 4; g++) begin
      v(0, 4'b1111, 0, 0, 1 << g, 0, 0, 1, g);
      for (int b = 0; b < 3; b++)
        v(0, 4'b1111, 0, 0, 1 << g, 1, dat(g), 1, g);
      v(0, 4'b1111, 0, 0, 0, 1, dat(g), 0, g);
    end
    v(0, 4'b1111, 0, 0, 4'b0001, 0, 0, 1, 0);
    // req_last ends producer 2 burst after 2 beats
    v(1, 4'b1111, 0, 0, 0, 0, 0, 0, 0);
    v(0, 4'b0100, 0, 0, 0, 0, 0, 0, 0);
    v(0, 4'b0100, 0, 0, 4'b0100, 0, 0, 1, 2);
    v(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, dat(2), 1, 2);
    v(0, 0, 0, 0, 0, 1, dat(2), 0, 2);
    v(0, 0, 0, 0, 0, 0, 0, 0, 2);
    v(0, 0, 0, 0, 0, 0, 0, 0, 2);
    // release by dropping req_vld, then full burst restarts count
    v(0, 4'b1000, 0, 0, 0, 0, 0, 0, 2);
    v(0, 4'b1000, 0, 0, 4'b1000, 0, 0, 1, 3);
    v(0, 4'b0001, 0, 0, 4'b1000, 1, dat(3), 1, 3);
    v(0, 4'b0001, 0, 0, 0, 0, 0, 0, 3);
    v(0, 4'b0001, 0, 0, 4'b0001, 0, 0, 1, 0);
    v(0, 4'b0001, 0, 0, 4'b0001, 1, dat(0), 1, 0);
    v(0, 4'b0001, 0, 0, 4'b0001, 1, dat(0), 1, 0);
    v(0, 4'b0001, 0, 0, 4'b0001, 1, dat(0), 1, 0);
    v(0, 0, 0, 0, 0, 1, dat(0), 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // full backpressure from fifo_num plus in-flight write
    v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 4'b0001, 0, 6, 0, 0, 0, 0, 0);
    v(0, 4'b0001, 0, 6, 4'b0001, 0, 0, 1, 0);
    v(0, 4'b0001, 0, 7, 0, 1, dat(0), 1, 0);
    v(0, 4'b0001, 0, 8, 0, 0, 0, 1, 0);
    v(0, 4'b0001, 0, 8, 0, 0, 0, 1, 0);
    v(0, 4'b0001, 0, 7, 4'b0001, 0, 0, 1, 0);
    v(0, 4'b0001, 0, 8, 0, 1, dat(0), 1, 0);
    v(0, 0, 0, 0, 4'b0001, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // producer 0 arrives during burst 1
    v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 4'b1010, 4'b1111, 0, 0, 0, 0, 0, 0);
    v(0, 4'b1011, 4'b1111, 0, 4'b0010, 0, 0, 1, 1);
    v(0, 4'b1011, 4'b1111, 0, 0, 1, dat(1), 0, 1);
    v(0, 4'b1011, 4'b1111, 0, 1 << P1, 0, 0, 1, P1);
    v(0, 1 << P2, 4'b1111, 0, 0, 1, dat(P1), 0, P1);
    v(0, 1 << P2, 4'b1111, 0, 1 << P2, 0, 0, 1, P2);

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst          = q[i].rst;
      bus.req_vld  = q[i].vld;
      bus.req_last = q[i].last;
      bus.fifo_num = q[i].num;
      #1;
      check("vec", i, q[i]);
    end

    // asynchronous reset asserted between edges mid-burst
    @(negedge clk);
    rst          = 1'b0;
    bus.req_vld  = 4'b0100;
    bus.req_last = '0;
    bus.fifo_num = '0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    e = '{rst:0, vld:0, last:0, num:0, rdy:4'b0100, wr:1,
          data:dat(2), gv:1, gid:2, chkd:1};
    check("pre_async_rst", 0, e);
    #1;
    rst = 1'b1;
    #1;
    e = '{rst:1, vld:0, last:0, num:0, rdy:0, wr:0,
          data:0, gv:0, gid:0, chkd:1};
    check("async_rst", 0, e);
    @(negedge clk);
    rst         = 1'b0;
    bus.req_vld = 4'b1111;
    @(negedge clk);
    #1;
    e = '{rst:0, vld:0, last:0, num:0, rdy:4'b0001, wr:0,
          data:0, gv:1, gid:0, chkd:0};
    check("post_rst_grant", 0, e);

    $display("== %0d vectors applied, %0d miscompares ==", napp, nbad);
    $finish;
  end

endmodule
